// File: rtl/l2_req_arbiter_pkg.sv
// Shared widths, client indices and FSM state encoding for the L2 request front end.
package l2_req_arbiter_pkg;

  localparam int unsigned L2_ADDR_W = 28;
  localparam int unsigned L2_DATA_W = 128;

  // Client slots in the request/grant vectors
  localparam int unsigned CLI_I = 0;
  localparam int unsigned CLI_D = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/l2_req_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer only moves when both clients contend.
module l2_req_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr = 0 favours req[0], ptr = 1 favours req[1]
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Merges I-cache and D-cache block misses/write-backs onto a single L2 port,
// one outstanding transaction at a time, with registered completion pulses.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = L2_ADDR_W,
  parameter int unsigned DATA_W = L2_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ready
);

  state_t     state;
  logic [1:0] mask;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       arb_en;

  // The client served last is still requesting during the first IDLE cycle
  assign req    = {d_read | d_write, i_read} & ~mask;
  assign arb_en = (state == ST_IDLE);

  l2_req_arbiter_rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (proc_reset),
    .req (req),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state    <= ST_IDLE;
      mask     <= 2'b00;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      l2_addr  <= '0;
      l2_wdata <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          mask <= 2'b00;
          if (gnt[CLI_I]) begin
            state    <= ST_BUSY_I;
            l2_read  <= 1'b1;
            l2_write <= 1'b0;
            l2_addr  <= i_addr;
          end else if (gnt[CLI_D]) begin
            // A write-back takes precedence over a read raised alongside it
            state    <= ST_BUSY_D;
            l2_read  <= ~d_write;
            l2_write <= d_write;
            l2_addr  <= d_addr;
            l2_wdata <= d_wdata;
          end
        end
        ST_BUSY_I: begin
          if (l2_ready) begin
            state    <= ST_RESP;
            i_rdata  <= l2_rdata;
            i_ready  <= 1'b1;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            mask     <= 2'b01;
          end
        end
        ST_BUSY_D: begin
          if (l2_ready) begin
            state    <= ST_RESP;
            d_rdata  <= l2_rdata;
            d_ready  <= 1'b1;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            mask     <= 2'b10;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
